// File: rtl/ffport_ctrl.sv
// VME-side controller for the DMB external data FIFOs: command decode, write/load pulses,
// read-advance, sliced read-back, channel select and DTACK. Optional counter: FFPORT_WCNT_EN.
module ffport_ctrl #(
  parameter int NFF     = 7,
  parameter int FFW     = 19,
  parameter int WEN_CYC = 2
) (
  input  logic            FASTCLK,
  input  logic            RST,
  input  logic            STROBE,
  input  logic            WRITE_B,
  input  logic            DEVICE,
  input  logic [9:0]      COMMAND,
  input  logic [15:0]     INDATA,
  input  logic [FFW-1:0]  FF_RD_DATA,
  output logic            RDFFNXT,
  output logic            LDFFCLK,
  output logic            FFWEN_B,
  output logic            TOFF_B,
  output logic [NFF-1:0]  ENAFF,
  output logic            DTACK_B,
  output logic [15:0]     OUTDATA,
  output logic            OUTDATA_OE
);

  localparam logic [2:0] PCNT_LAST = 3'(WEN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_PULSE,
    ACK,
    INC,
    WAIT_REL
  } state_t;

  state_t         state_reg, state_next;
  logic [2:0]     pcnt_reg, pcnt_next;
  logic           inc_reg, inc_next;
  logic           ffwen_b_reg, ffwen_b_next;
  logic           ldffclk_reg, ldffclk_next;
  logic           rdffnxt_reg, rdffnxt_next;
  logic           dtack_b_reg, dtack_b_next;
  logic [NFF-1:0] enaff_reg, enaff_next;

  logic cmd_write, cmd_read, cmd_sel_wr, cmd_sel_rd, cmd_inc;
  logic cmd_cnt_rd, cmd_cnt_clr;
  logic [15:0] rd_data;
  logic [15:0] slice_word [8];
  logic unused_indata;

  assign unused_indata = ^INDATA;

  assign cmd_write  = DEVICE & (COMMAND[9:2] == 8'h00);
  assign cmd_read   = DEVICE & (COMMAND[9:4] == 6'h01);
  assign cmd_sel_wr = DEVICE & (COMMAND == 10'h008);
  assign cmd_sel_rd = DEVICE & (COMMAND == 10'h009);
  assign cmd_inc    = DEVICE & (COMMAND == 10'h00B);

  // Slices wholly beyond the FIFO word read as zero; a partial top slice is zero-extended.
  for (genvar gi = 0; gi < 8; gi++) begin : g_slice
    if ((gi + 1) * 16 <= FFW) begin : g_full
      assign slice_word[gi] = FF_RD_DATA[gi*16 +: 16];
    end else if (gi * 16 < FFW) begin : g_part
      assign slice_word[gi] = {{((gi + 1) * 16 - FFW){1'b0}}, FF_RD_DATA[FFW-1:gi*16]};
    end else begin : g_none
      assign slice_word[gi] = '0;
    end
  end

`ifdef FFPORT_WCNT_EN
  logic [15:0] wcnt_reg;

  assign cmd_cnt_rd  = DEVICE & (COMMAND == 10'h00C);
  assign cmd_cnt_clr = DEVICE & (COMMAND == 10'h00D);

  // Clear wins over a coincident load pulse; count saturates instead of wrapping.
  always_ff @(posedge FASTCLK or posedge RST) begin
    if (RST) begin
      wcnt_reg <= '0;
    end else if (state_reg == IDLE && STROBE && cmd_cnt_clr) begin
      wcnt_reg <= '0;
    end else if (ldffclk_next && wcnt_reg != 16'hFFFF) begin
      wcnt_reg <= wcnt_reg + 16'd1;
    end
  end
`else
  assign cmd_cnt_rd  = 1'b0;
  assign cmd_cnt_clr = 1'b0;
`endif

  always_ff @(posedge FASTCLK or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      pcnt_reg    <= '0;
      inc_reg     <= 1'b0;
      ffwen_b_reg <= 1'b1;
      ldffclk_reg <= 1'b0;
      rdffnxt_reg <= 1'b0;
      dtack_b_reg <= 1'b1;
      enaff_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pcnt_reg    <= pcnt_next;
      inc_reg     <= inc_next;
      ffwen_b_reg <= ffwen_b_next;
      ldffclk_reg <= ldffclk_next;
      rdffnxt_reg <= rdffnxt_next;
      dtack_b_reg <= dtack_b_next;
      enaff_reg   <= enaff_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pcnt_next    = pcnt_reg;
    inc_next     = inc_reg;
    ffwen_b_next = 1'b1;
    ldffclk_next = 1'b0;
    rdffnxt_next = 1'b0;
    dtack_b_next = 1'b1;
    enaff_next   = enaff_reg;
    case (state_reg)
      IDLE: begin
        if (STROBE) begin
          if (cmd_write) begin
            state_next = WR_PULSE;
            pcnt_next  = '0;
          end else if (cmd_read || cmd_sel_rd || cmd_cnt_rd) begin
            state_next = ACK;
            inc_next   = cmd_read & COMMAND[0];
          end else if (cmd_sel_wr) begin
            state_next = ACK;
            inc_next   = 1'b0;
            enaff_next = INDATA[NFF-1:0];
          end else if (cmd_cnt_clr) begin
            state_next = ACK;
            inc_next   = 1'b0;
          end else if (cmd_inc) begin
            state_next = ACK;
            inc_next   = 1'b1;
          end
        end
      end
      WR_PULSE: begin
        // Losing the strobe mid-pulse abandons the write without a load or acknowledge.
        if (!STROBE) begin
          state_next = IDLE;
        end else begin
          ffwen_b_next = 1'b0;
          if (pcnt_reg == PCNT_LAST) begin
            ldffclk_next = 1'b1;
            state_next   = ACK;
          end else begin
            pcnt_next = pcnt_reg + 3'd1;
          end
        end
      end
      ACK: begin
        if (STROBE) begin
          dtack_b_next = 1'b0;
        end else begin
          rdffnxt_next = inc_reg;
          state_next   = inc_reg ? INC : WAIT_REL;
        end
      end
      INC:      state_next = WAIT_REL;
      WAIT_REL: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (cmd_read) begin
      rd_data = slice_word[COMMAND[3:1]];
    end else if (cmd_sel_rd) begin
      rd_data = {{(16 - NFF){1'b0}}, enaff_reg};
    end
`ifdef FFPORT_WCNT_EN
    else if (cmd_cnt_rd) begin
      rd_data = wcnt_reg;
    end
`endif
  end

  assign OUTDATA_OE = ~RST & STROBE & WRITE_B & (cmd_read | cmd_sel_rd | cmd_cnt_rd);
  assign OUTDATA    = OUTDATA_OE ? rd_data : 16'h0000;
  assign TOFF_B     = ~(STROBE & cmd_write & ~WRITE_B);
  assign RDFFNXT    = rdffnxt_reg;
  assign LDFFCLK    = ldffclk_reg;
  assign FFWEN_B    = ffwen_b_reg;
  assign DTACK_B    = dtack_b_reg;
  assign ENAFF      = enaff_reg;

endmodule
